// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: SPI pin bundle plus the register-bank side outputs of spi_reg_bank.
//   slave  modport: used by the peripheral (SPI pins in, CIPO/status/registers out).
//   master modport: used by whatever drives the SPI pins and consumes the outputs.
// Signals:
//   nCS, SCLK, COPI   SPI inputs (mode 0, asynchronous to clk)
//   CIPO, cipo_oe     SPI read data and its output enable
//   regs_flat         register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe/wr_addr write pulse and address of the last committed write
//   frame_err/addr_err one-clk error pulses at frame release
//   busy              frame in progress
interface spi_reg_bank_if #(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
);
  logic                       nCS;
  logic                       SCLK;
  logic                       COPI;
  logic                       CIPO;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_strobe;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       frame_err;
  logic                       addr_err;
  logic                       busy;

  modport slave (
    input  nCS, SCLK, COPI,
    output CIPO, cipo_oe, regs_flat, wr_strobe, wr_addr, frame_err, addr_err, busy
  );

  modport master (
    output nCS, SCLK, COPI,
    input  CIPO, cipo_oe, regs_flat, wr_strobe, wr_addr, frame_err, addr_err, busy
  );
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral driving a bank of NUM_REGS control registers.
// Frame is RW bit, ADDR_W address bits, DATA_W data bits, MSB first. Writes commit on
// nCS release; reads shift reg[addr] out on CIPO during the data phase.
// Ports:
//   clk  system clock (>= 8x SCLK)
//   rst  synchronous active-high reset
//   bus  spi_reg_bank_if.slave: SPI pins, register outputs, write/error pulses, busy
module spi_reg_bank #(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  spi_reg_bank_if.slave bus
);

  localparam int unsigned FrameW = 1 + ADDR_W + DATA_W;
  localparam int unsigned CntW   = $clog2(FrameW + 1);
  // Count values seen just before the last command bit / after the command / before last bit
  localparam logic [CntW-1:0]   CmdLast   = CntW'(ADDR_W);
  localparam logic [CntW-1:0]   DataFirst = CntW'(ADDR_W + 1);
  localparam logic [CntW-1:0]   FrameLast = CntW'(FrameW - 1);
  localparam logic [ADDR_W:0]   NumRegsL  = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  // Input synchronisers
  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
  logic                   sclk_hist_q, ncs_hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '0;  // frame can only start after nCS is seen high
      copi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.nCS};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.COPI};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;

  // Frame state
  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [ADDR_W:0]     cmd_q;
  logic [DATA_W-1:0]   data_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   tx_q;
  logic                ovf_q;
  logic                busy_q;
  logic                oe_q;
  logic                cipo_q;

  // Commit decision is registered, then applied one clk later
  logic                pend_wr_q, pend_ferr_q, pend_aerr_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic [DATA_W-1:0]   pend_data_q;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                wr_strobe_q, frame_err_q, addr_err_q;
  logic [ADDR_W-1:0]   wr_addr_q;

  logic [ADDR_W:0]     cmd_next;
  logic [DATA_W-1:0]   rd_data;
  logic                addr_ok;
  logic                frame_bad;

  assign cmd_next  = {cmd_q[ADDR_W-1:0], copi_s};
  assign addr_ok   = {1'b0, addr_q} < NumRegsL;
  assign frame_bad = (state_q != StDone) | ovf_q;

  // Read mux over the address being completed; out-of-range reads return 0
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_next[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      tx_q        <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      oe_q        <= 1'b0;
      cipo_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_ferr_q <= 1'b0;
      pend_aerr_q <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pend_wr_q   <= 1'b0;
      pend_ferr_q <= 1'b0;
      pend_aerr_q <= 1'b0;
      wr_strobe_q <= pend_wr_q;
      frame_err_q <= pend_ferr_q;
      addr_err_q  <= pend_aerr_q;
      cipo_q      <= tx_q[DATA_W-1];
      if (pend_wr_q) wr_addr_q <= pend_addr_q;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pend_wr_q && pend_addr_q == ADDR_W'(i)) regs_q[i] <= pend_data_q;
      end

      if (state_q == StIdle) begin
        if (ncs_fall) begin
          cnt_q   <= '0;
          cmd_q   <= '0;
          data_q  <= '0;
          ovf_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= StCmd;
        end
      end else if (ncs_rise) begin
        // nCS release wins over a coincident SCLK edge
        if (frame_bad) begin
          pend_ferr_q <= 1'b1;
        end else if (!addr_ok) begin
          pend_aerr_q <= 1'b1;
        end else if (rw_q) begin
          pend_wr_q   <= 1'b1;
          pend_addr_q <= addr_q;
          pend_data_q <= data_q;
        end
        busy_q  <= 1'b0;
        oe_q    <= 1'b0;
        tx_q    <= '0;
        state_q <= StIdle;
      end else begin
        case (state_q)
          StCmd: begin
            if (sclk_rise) begin
              cmd_q <= cmd_next;
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CmdLast) begin
                rw_q    <= cmd_next[ADDR_W];
                addr_q  <= cmd_next[ADDR_W-1:0];
                state_q <= StData;
                if (!cmd_next[ADDR_W]) begin
                  tx_q <= rd_data;
                  oe_q <= 1'b1;
                end
              end
            end
          end
          StData: begin
            if (sclk_rise) begin
              data_q <= {data_q[DATA_W-2:0], copi_s};
              cnt_q  <= cnt_q + 1'b1;
              if (cnt_q == FrameLast) state_q <= StDone;
            end else if (sclk_fall && oe_q && cnt_q != DataFirst) begin
              // The fall right after the last address bit keeps the preloaded MSB on CIPO
              tx_q <= {tx_q[DATA_W-2:0], 1'b0};
            end
          end
          StDone: begin
            if (sclk_rise) ovf_q <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign bus.CIPO      = cipo_q & oe_q;
  assign bus.cipo_oe   = oe_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed testbench for spi_reg_bank with default parameters.
module tb_spi_reg_bank;
  localparam int Half = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0, ferr_cnt = 0, aerr_cnt = 0;
  int   wr0, ferr0, aerr0;
  logic [31:0] rx, oe;
  logic [39:0] regs_before;

  spi_reg_bank_if #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7)) bus ();

  spi_reg_bank #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.wr_strobe) wr_cnt++;
      if (bus.frame_err) ferr_cnt++;
      if (bus.addr_err)  aerr_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    wr0 = wr_cnt; ferr0 = ferr_cnt; aerr0 = aerr_cnt;
    regs_before = bus.regs_flat;
  endtask

  task automatic cs_low();
    bus.nCS = 1'b0;
    wait_clk(Half);
  endtask

  task automatic cs_high();
    wait_clk(Half);
    bus.nCS  = 1'b1;
    bus.COPI = 1'b0;
    wait_clk(10);
  endtask

  // Sends n bits from the top of bits; samples CIPO/cipo_oe just before each SCLK rise
  task automatic send_bits(input logic [31:0] bits, input int n);
    rx = '0; oe = '0;
    for (int i = 0; i < n; i++) begin
      bus.COPI = bits[31-i];
      wait_clk(Half);
      rx = {rx[30:0], bus.CIPO};
      oe = {oe[30:0], bus.cipo_oe};
      bus.SCLK = 1'b1;
      wait_clk(Half);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic frame16(input logic [15:0] w);
    cs_low();
    send_bits({w, 16'h0}, 16);
    cs_high();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.nCS = 1'b1; bus.SCLK = 1'b0; bus.COPI = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    checks++; if (bus.regs_flat !== 40'h0) begin errors++;
      $display("FAIL reset_regs got %h want 0", bus.regs_flat); end
    checks++; if (bus.wr_addr !== 7'h0) begin errors++;
      $display("FAIL reset_wr_addr got %h want 0", bus.wr_addr); end
    checks++; if ({bus.CIPO, bus.cipo_oe, bus.busy} !== 3'b000) begin errors++;
      $display("FAIL reset_cipo_oe_busy got %b want 000", {bus.CIPO, bus.cipo_oe, bus.busy}); end
    checks++; if ({bus.wr_strobe, bus.frame_err, bus.addr_err} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses got %b want 000",
               {bus.wr_strobe, bus.frame_err, bus.addr_err}); end
  endtask

  task automatic test_write();
    snap();
    cs_low();
    checks++; if (bus.busy !== 1'b1) begin errors++;
      $display("FAIL write_busy got %b want 1", bus.busy); end
    send_bits({16'h84F0, 16'h0}, 16);
    cs_high();
    checks++; if (bus.regs_flat !== 40'hF0_0000_0000) begin errors++;
      $display("FAIL write_regs got %h want f000000000", bus.regs_flat); end
    checks++; if (wr_cnt - wr0 != 1) begin errors++;
      $display("FAIL write_strobe_count got %0d want 1", wr_cnt - wr0); end
    checks++; if (bus.wr_addr !== 7'd4) begin errors++;
      $display("FAIL write_wr_addr got %0d want 4", bus.wr_addr); end
    checks++; if ((ferr_cnt - ferr0) + (aerr_cnt - aerr0) != 0) begin errors++;
      $display("FAIL write_err_pulses got %0d want 0", (ferr_cnt - ferr0) + (aerr_cnt - aerr0)); end
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL write_busy_after got %b want 0", bus.busy); end
  endtask

  task automatic test_read();
    snap();
    frame16(16'h0400);
    checks++; if (rx[7:0] !== 8'hF0) begin errors++;
      $display("FAIL read_cipo_data got %h want f0", rx[7:0]); end
    checks++; if (oe[15:0] !== 16'h00FF) begin errors++;
      $display("FAIL read_cipo_oe_window got %h want 00ff", oe[15:0]); end
    checks++; if (bus.regs_flat !== regs_before) begin errors++;
      $display("FAIL read_regs_unchanged got %h want %h", bus.regs_flat, regs_before); end
    checks++; if (wr_cnt - wr0 != 0) begin errors++;
      $display("FAIL read_no_strobe got %0d want 0", wr_cnt - wr0); end
    checks++; if ({bus.cipo_oe, bus.CIPO} !== 2'b00) begin errors++;
      $display("FAIL read_oe_after got %b want 00", {bus.cipo_oe, bus.CIPO}); end
  endtask

  task automatic test_errors();
    snap();
    frame16(16'h8555);
    checks++; if (aerr_cnt - aerr0 != 1 || ferr_cnt - ferr0 != 0) begin errors++;
      $display("FAIL addr_err_pulse got aerr %0d ferr %0d want 1 0",
               aerr_cnt - aerr0, ferr_cnt - ferr0); end
    checks++; if (bus.regs_flat !== regs_before || wr_cnt != wr0) begin errors++;
      $display("FAIL addr_err_no_write got %h/%0d want %h/0", bus.regs_flat, wr_cnt - wr0,
               regs_before); end

    snap();
    cs_low(); send_bits({16'h81AA, 16'h0}, 15); cs_high();
    checks++; if (ferr_cnt - ferr0 != 1 || aerr_cnt - aerr0 != 0) begin errors++;
      $display("FAIL short_frame_err got ferr %0d aerr %0d want 1 0",
               ferr_cnt - ferr0, aerr_cnt - aerr0); end
    checks++; if (bus.regs_flat[15:8] !== 8'h00 || wr_cnt != wr0) begin errors++;
      $display("FAIL short_frame_reg1 got %h/%0d want 00/0", bus.regs_flat[15:8], wr_cnt - wr0);
    end

    snap();
    cs_low(); send_bits({16'h8155, 1'b1, 15'h0}, 17); cs_high();
    checks++; if (ferr_cnt - ferr0 != 1) begin errors++;
      $display("FAIL long_frame_err got %0d want 1", ferr_cnt - ferr0); end
    checks++; if (bus.regs_flat !== regs_before || wr_cnt != wr0) begin errors++;
      $display("FAIL long_frame_no_write got %h/%0d want %h/0", bus.regs_flat, wr_cnt - wr0,
               regs_before); end
  endtask

  task automatic test_reset_midframe();
    snap();
    cs_low();
    send_bits({16'h83FF, 16'h0}, 9);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    send_bits({16'h83FF, 16'h0} << 9, 7);
    cs_high();
    checks++; if (bus.regs_flat !== 40'h0) begin errors++;
      $display("FAIL midrst_regs got %h want 0", bus.regs_flat); end
    checks++; if (wr_cnt != wr0 || ferr_cnt != ferr0 || aerr_cnt != aerr0) begin errors++;
      $display("FAIL midrst_pulses got wr %0d ferr %0d aerr %0d want 0 0 0",
               wr_cnt - wr0, ferr_cnt - ferr0, aerr_cnt - aerr0); end
    frame16(16'h8312);
    checks++; if (bus.regs_flat !== 40'h00_1200_0000) begin errors++;
      $display("FAIL midrst_next_write got %h want 0012000000", bus.regs_flat); end
    checks++; if (bus.wr_addr !== 7'd3) begin errors++;
      $display("FAIL midrst_wr_addr got %0d want 3", bus.wr_addr); end
  endtask

  task automatic test_back_to_back();
    snap();
    cs_low();
    send_bits({16'h8001, 16'h0}, 16);
    wait_clk(Half);
    bus.nCS = 1'b1;
    wait_clk(3);
    bus.nCS = 1'b0;
    wait_clk(Half);
    send_bits({16'h8102, 16'h0}, 16);
    cs_high();
    checks++; if (bus.regs_flat !== 40'h00_1200_0201) begin errors++;
      $display("FAIL b2b_regs got %h want 0012000201", bus.regs_flat); end
    checks++; if (wr_cnt - wr0 != 2) begin errors++;
      $display("FAIL b2b_strobes got %0d want 2", wr_cnt - wr0); end
    checks++; if (bus.wr_addr !== 7'd1) begin errors++;
      $display("FAIL b2b_wr_addr got %0d want 1", bus.wr_addr); end
  endtask

  task automatic test_coincident();
    logic [31:0] w;
    w = {16'h8277, 16'h0};
    snap();
    cs_low();
    send_bits(w, 15);
    bus.COPI = w[16];
    wait_clk(Half);
    bus.SCLK = 1'b1;
    bus.nCS  = 1'b1;
    wait_clk(Half);
    bus.SCLK = 1'b0;
    wait_clk(10);
    checks++; if (ferr_cnt - ferr0 != 1) begin errors++;
      $display("FAIL coincident_frame_err got %0d want 1", ferr_cnt - ferr0); end
    checks++; if (bus.regs_flat !== regs_before || wr_cnt != wr0) begin errors++;
      $display("FAIL coincident_no_write got %h/%0d want %h/0", bus.regs_flat, wr_cnt - wr0,
               regs_before); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_reset_midframe();
    test_back_to_back();
    test_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI (mode 0) peripheral that drives a bank of NUM_REGS control registers.
- Supports register write and register read-back over CIPO.
- Rejects malformed frames with error pulses.
- Sits between the chip's SPI pins and downstream config consumers (output enables, PWM enables, duty cycle, future blocks); intended successor to the fixed 5-register write-only SPI peripheral.

Parameters:
- NUM_REGS, 5, number of implemented registers (1..2^ADDR_W).
- DATA_W, 8, register width and data-phase bit count.
- ADDR_W, 7, address field width.
- SYNC_STAGES, 2, synchroniser depth for SCLK/nCS/COPI (>=2).

Ports:
- clk  input  1  system clock; must be >= 8x SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- nCS  input  1  SPI chip select, active low, asynchronous to clk.
- SCLK  input  1  SPI clock, idle low, asynchronous to clk.
- COPI  input  1  controller-out data, sampled on SCLK rise.
- CIPO  output  1  peripheral-out data, launched on SCLK fall.
- cipo_oe  output  1  high while a read data phase is active.
- regs_flat  output  NUM_REGS*DATA_W  register contents; reg i at [i*DATA_W +: DATA_W].
- wr_strobe  output  1  one-clk pulse when a register is written.
- wr_addr  output  ADDR_W  address of the last committed write.
- frame_err  output  1  one-clk pulse on bad bit count at nCS release.
- addr_err  output  1  one-clk pulse on out-of-range address at nCS release.
- busy  output  1  high from frame start until commit/abort.

Behaviour:
- Clock and reset:
  - Single clock domain clk.
  - rst is synchronous and active-high.
  - Reset values:
    - regs_flat = 0, wr_addr = 0.
    - wr_strobe, frame_err, addr_err, cipo_oe, busy, CIPO = 0.
    - Bit counter = 0, state = IDLE.
- Input synchronisation:
  - SCLK, nCS and COPI each pass through SYNC_STAGES flops plus one history flop; edges are detected on the synchronised signal.
  - On reset, the nCS synchroniser loads 0, so a frame can only start after nCS is seen high. A reset while nCS is low therefore ignores the remainder of that frame.
- Frame format:
  - FRAME_W = 1 + ADDR_W + DATA_W bits, MSB first.
  - Bit 0 of the frame is RW (1 = write, 0 = read), followed by the address, then data.
- States:
  - IDLE: waiting for a synchronised nCS falling edge. On that edge, clear the bit counter and shift register, set busy, go to CMD.
  - CMD: shift COPI on each synced SCLK rise. After 1+ADDR_W bits, latch rw and addr, then go to DATA.
    - For a read, load the tx shifter with reg[addr], or 0 if addr >= NUM_REGS, and assert cipo_oe.
  - DATA: shift COPI on each SCLK rise. For a read, shift tx on each synced SCLK fall; CIPO = tx MSB.
    - The first read data bit is valid on CIPO before the first data-phase SCLK rise.
    - After DATA_W bits, go to DONE.
  - DONE: further SCLK rises set an overflow flag and are otherwise ignored.
  - Any state except IDLE: a synced nCS rising edge is a commit, then return to IDLE.
- Commit (nCS rising edge):
  - Bit count != FRAME_W, or overflow: pulse frame_err, write nothing.
  - Otherwise, addr >= NUM_REGS: pulse addr_err, write nothing.
  - Otherwise, if rw = 1: reg[addr] <= data and wr_addr <= addr, with wr_strobe pulsed in the same clk the new value appears.
  - A read frame never modifies any register.
  - busy and cipo_oe drop at commit. CIPO is 0 whenever cipo_oe = 0.
- Latency:
  - A pin nCS rise appears on regs_flat/wr_strobe after SYNC_STAGES+2 clk edges, with +1 uncertainty from asynchronous sampling.
  - A pin SCLK fall appears on CIPO after SYNC_STAGES+2 clk edges.
- Simultaneous events:
  - A synced nCS rise coinciding with a synced SCLK rise: nCS wins and that SCLK edge is not counted.
  - An nCS rise while in IDLE is ignored.
  - rst has priority over every event.
- Register width rules:
  - Data bits beyond DATA_W are not shifted into registers.
  - Address comparison uses the full ADDR_W bits; there is no aliasing or wrap-around.

Test Plan:
- Write frame 0x84F0 (RW=1, addr 4, data 0xF0), default params: regs_flat[39:32] = 0xF0, wr_strobe pulses exactly once, wr_addr = 4, no error pulses.
- After the previous write, read frame 0x0400: CIPO shifts out 1111_0000 MSB first over the data phase, cipo_oe high only in DATA, regs unchanged, no wr_strobe.
- Write frame 0x8555 (addr 5, out of range): addr_err pulse, all regs unchanged. Then 15-bit frame 0x81AA: frame_err pulse, reg1 unchanged. Then 17-bit frame: frame_err pulse, no write.
- Assert rst for 1 clk mid-frame after 9 bits of 0x83FF with nCS held low, then complete the frame: all regs 0, no write, no error pulse. The next full frame 0x8312 writes reg3 = 0x12.
- Back-to-back writes 0x8001 then 0x8102 with nCS high for 3 clk between frames: reg0 = 0x01 and reg1 = 0x02, two wr_strobe pulses. Also drive nCS rise coincident with the 16th SCLK rise after sync: frame_err, no write.
